// File: rtl/decoder_pkg.sv
// Shared constants and tree-shape helpers for the enabled one-hot decoder.
// Used by enabled_decoder and its testbench.
package decoder_pkg;

  localparam int MAX_SEL_W = 6;

  typedef logic [MAX_SEL_W-1:0] sel_t;

  // Number of select bits the root leaf consumes: 1:2 for odd widths, 2:4 for even.
  function automatic int root_bits(input int sel_w);
    return (sel_w % 2 == 1) ? 1 : 2;
  endfunction

  function automatic int num_levels(input int sel_w);
    return (sel_w + 1) / 2;
  endfunction

  function automatic int leaf_count(input int sel_w, input int lvl);
    return (lvl == 0) ? 1 : (1 << (root_bits(sel_w) + 2 * (lvl - 1)));
  endfunction

  function automatic int level_width(input int sel_w, input int lvl);
    return (lvl == 0) ? (1 << root_bits(sel_w)) : 4 * leaf_count(sel_w, lvl);
  endfunction

endpackage

// File: rtl/decoder2_4.sv
// 2:4 enabled decoder leaf: out_o[i] = en_i & (sel_i == i).
// Written as AND terms so a disabled leaf stays zero even with an unknown select.
module decoder2_4 (
  input  logic       en_i,
  input  logic [1:0] sel_i,
  output logic [3:0] out_o
);

  assign out_o[0] = en_i & ~sel_i[1] & ~sel_i[0];
  assign out_o[1] = en_i & ~sel_i[1] &  sel_i[0];
  assign out_o[2] = en_i &  sel_i[1] & ~sel_i[0];
  assign out_o[3] = en_i &  sel_i[1] &  sel_i[0];

endmodule

// File: rtl/enabled_decoder.sv
// Enable-gated binary-to-one-hot decoder built as a tree of 1:2 / 2:4 leaves,
// with a registered copy of the output. Define ENABLED_DECODER_ONEHOT_CHECK_EN for the sticky onehot_err checker.
module enabled_decoder
  import decoder_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int OUT_W = 1 << SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] out,
  output logic [OUT_W-1:0] out_q,
  output logic             en_q
`ifdef ENABLED_DECODER_ONEHOT_CHECK_EN
  ,
  output logic             onehot_err
`endif
);

  localparam int NLVL  = num_levels(SEL_W);
  localparam int RBITS = root_bits(SEL_W);

  // Level 0 is the root; each later level splits every enable of the previous
  // level with a 2:4 leaf on the next two lower select bits.
  for (genvar l = 0; l < NLVL; l++) begin : g_lvl
    localparam int W = level_width(SEL_W, l);
    logic [W-1:0] dec;

    if (l == 0) begin : g_root
      if (RBITS == 1) begin : g_1to2
        assign dec[1] = en &  sel[SEL_W-1];
        assign dec[0] = en & ~sel[SEL_W-1];
      end else begin : g_2to4
        decoder2_4 u_leaf (
          .en_i  (en),
          .sel_i (sel[SEL_W-1 -: 2]),
          .out_o (dec)
        );
      end
    end else begin : g_tree
      localparam int NLEAF = leaf_count(SEL_W, l);
      localparam int LO    = SEL_W - RBITS - 2 * l;
      for (genvar k = 0; k < NLEAF; k++) begin : g_leaf
        decoder2_4 u_leaf (
          .en_i  (g_lvl[l-1].dec[k]),
          .sel_i (sel[LO +: 2]),
          .out_o (dec[4*k +: 4])
        );
      end
    end
  end

  assign out = g_lvl[NLVL-1].dec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      en_q  <= 1'b0;
    end else begin
      out_q <= out;
      en_q  <= en;
    end
  end

`ifdef ENABLED_DECODER_ONEHOT_CHECK_EN
  logic bad_pattern;
  logic onehot_err_q;

  // Flags more than one bit set, or any bit set while disabled.
  assign bad_pattern = ((out & (out - OUT_W'(1))) != '0) || (!en && (out != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      onehot_err_q <= 1'b0;
    end else if (bad_pattern) begin
      onehot_err_q <= 1'b1;
    end
  end

  assign onehot_err = onehot_err_q;

`ifndef SYNTHESIS
  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) !bad_pattern);
`endif
`endif

endmodule

// File: tb/tb_enabled_decoder.sv
// Self-checking bench for enabled_decoder at SEL_W = 3, 1 and 6 against a
// shift-based one-hot reference; covers ENABLED_DECODER_ONEHOT_CHECK_EN when defined.
module tb_enabled_decoder;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic [2:0]  sel3  = '0;
  logic [0:0]  sel1  = '0;
  logic [5:0]  sel6  = '0;
  logic [7:0]  out3, out_q3;
  logic [1:0]  out1, out_q1;
  logic [63:0] out6, out_q6;
  logic        en_q3, en_q1, en_q6;
`ifdef ENABLED_DECODER_ONEHOT_CHECK_EN
  logic        err3, err1, err6;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  enabled_decoder #(.SEL_W(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .sel(sel3),
    .out(out3), .out_q(out_q3), .en_q(en_q3)
`ifdef ENABLED_DECODER_ONEHOT_CHECK_EN
    , .onehot_err(err3)
`endif
  );

  enabled_decoder #(.SEL_W(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .sel(sel1),
    .out(out1), .out_q(out_q1), .en_q(en_q1)
`ifdef ENABLED_DECODER_ONEHOT_CHECK_EN
    , .onehot_err(err1)
`endif
  );

  enabled_decoder #(.SEL_W(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .en(en), .sel(sel6),
    .out(out6), .out_q(out_q6), .en_q(en_q6)
`ifdef ENABLED_DECODER_ONEHOT_CHECK_EN
    , .onehot_err(err6)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: the selected bit position as a power of two, or nothing when disabled.
  function automatic logic [63:0] ref_onehot(input bit e, input int s);
    return e ? (64'd1 << s) : 64'd0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] e64, exp3, exp1, exp6;
    logic        exp_en;

    #1;
    chk("rst_out_q3", out_q3, 64'd0);
    chk("rst_en_q3",  en_q3,  64'd0);
    chk("rst_out_q1", out_q1, 64'd0);
    chk("rst_out_q6", out_q6, 64'd0);
`ifdef ENABLED_DECODER_ONEHOT_CHECK_EN
    chk("rst_onehot_err", err3, 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 16; v++) begin
      en   = v[3];
      sel3 = v[2:0];
      #1;
      e64 = ref_onehot(en, int'(sel3));
      chk($sformatf("sweep_v%0d", v), out3, e64);
      for (int b = 0; b < 8; b++)
        chk($sformatf("sweep_v%0d_b%0d", v, b), out3[b], e64[b]);
      if (v == 13) chk("sweep_en1_sel5", out3, 64'h20);
      if (v < 8)   chk($sformatf("sweep_en0_v%0d", v), out3, 64'h00);
    end

    @(negedge clk);
    en = 1'b1; sel3 = 3'd2;
    @(posedge clk); #1;
    chk("reg_out_q_sel2", out_q3, 64'h04);
    chk("reg_en_q_1",     en_q3,  64'd1);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk); #1;
    chk("reg_out_q_off", out_q3, 64'h00);
    chk("reg_en_q_0",    en_q3,  64'd0);

    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      en   = ($urandom_range(0, 3) != 0);
      sel3 = 3'($urandom);
      sel1 = 1'($urandom);
      sel6 = 6'($urandom);
      #1;
      exp3   = ref_onehot(en, int'(sel3));
      exp1   = ref_onehot(en, int'(sel1));
      exp6   = ref_onehot(en, int'(sel6));
      exp_en = en;
      chk("rand_out3", out3, exp3);
      chk("rand_out1", out1, exp1);
      chk("rand_out6", out6, exp6);
      @(posedge clk); #1;
      chk("rand_out_q3", out_q3, exp3);
      chk("rand_out_q1", out_q1, exp1);
      chk("rand_out_q6", out_q6, exp6);
      chk("rand_en_q3",  en_q3,  exp_en);
      chk("rand_en_q6",  en_q6,  exp_en);
    end

    @(negedge clk);
    en = 1'b1; sel3 = 3'd7;
    @(posedge clk); #1;
    chk("arst_pre_out_q", out_q3, 64'h80);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_q",  out_q3, 64'h00);
    chk("arst_en_q",   en_q3,  64'd0);
    chk("arst_out",    out3,   64'h80);
    chk("arst_out_q6", out_q6, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_resume_out_q", out_q3, 64'h80);
    chk("arst_resume_en_q",  en_q3,  64'd1);

    @(negedge clk);
    en = 1'b1; sel1 = 1'b1; sel6 = 6'd63;
    #1;
    chk("corner_w1_sel1",  out1, 64'h2);
    chk("corner_w6_sel63", out6, 64'h8000_0000_0000_0000);
    sel6 = 6'd0;
    #1;
    chk("corner_w6_sel0",  out6, 64'h1);

    en = 1'b0; sel3 = 'x; sel6 = 'x;
    #1;
    chk("xsafe_out3", out3, 64'd0);
    chk("xsafe_out6", out6, 64'd0);
    sel3 = '0; sel6 = '0;

`ifdef ENABLED_DECODER_ONEHOT_CHECK_EN
    @(negedge clk);
    en = 1'b1; sel3 = 3'd1;
    #1;
    chk("checker_clear", err3, 64'd0);
    force u_dut3.out = 8'h03;
    @(posedge clk); #1;
    chk("checker_set", err3, 64'd1);
    @(negedge clk);
    release u_dut3.out;
    repeat (3) @(posedge clk);
    #1;
    chk("checker_sticky", err3, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("checker_reset", err3, 64'd0);
    rst_n = 1'b1;
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
